// File: rtl/sfp_div_seq.sv
// Sequential signed fixed-point divider (IW.QW / IW.QW -> IW.QW).
// Unsigned restoring division on magnitudes, one quotient bit per cycle,
// followed by sign application and saturation. Divide-by-zero is flagged
// and returns the saturated value matching the dividend's sign.
module sfp_div_seq #(
  parameter int unsigned IW = 8,
  parameter int unsigned QW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IW+QW-1:0]     a_i,
  input  logic [IW+QW-1:0]     b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IW+QW-1:0]     q_o,
  output logic                 dbz_o,
  output logic                 ovf_o
);

  localparam int unsigned WL = IW + QW;
  localparam int unsigned N  = WL + QW;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WL-1:0] QMAX = {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] QMIN = {1'b1, {(WL-1){1'b0}}};

  logic [1:0]    state_q;
  logic          sign_q;
  logic          dbz_q;
  logic [N-1:0]  dvd_q;
  logic [WL-1:0] dvs_q;
  logic [WL-1:0] rem_q;
  logic [N-1:0]  quo_q;
  logic [CW-1:0] cnt_q;

  logic [WL-1:0] a_mag;
  logic [WL-1:0] b_mag;
  logic [WL:0]   rem_shift;
  logic          rem_ge;
  logic [WL-1:0] rem_next;
  logic          accept;
  logic          pos_ovf;
  logic          neg_ovf;

  // Two's-complement magnitude; the most negative value maps to 2^(WL-1) unsigned.
  assign a_mag = a_i[WL-1] ? (~a_i + 1'b1) : a_i;
  assign b_mag = b_i[WL-1] ? (~b_i + 1'b1) : b_i;

  // Remainder stays below the divisor (<= 2^(WL-1)), so WL bits hold it after subtraction.
  assign rem_shift = {rem_q, dvd_q[N-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  assign rem_next  = rem_ge ? (rem_shift[WL-1:0] - dvs_q) : rem_shift[WL-1:0];

  assign accept     = (state_q == IDLE) && in_valid_i;
  assign in_ready_o = (state_q == IDLE);

  assign pos_ovf = quo_q > {{QW{1'b0}}, QMAX};
  assign neg_ovf = quo_q > {{QW{1'b0}}, QMIN};

  // Control FSM and restoring-division datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      dbz_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            sign_q  <= a_i[WL-1] ^ b_i[WL-1];
            dbz_q   <= (b_i == '0);
            dvd_q   <= {a_mag, {QW{1'b0}}};
            dvs_q   <= b_mag;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          // A zero divisor spends a single cycle here before reporting.
          if (dbz_q) begin
            state_q <= DONE;
          end else begin
            dvd_q <= dvd_q << 1;
            rem_q <= rem_next;
            quo_q <= {quo_q[N-2:0], rem_ge};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result formatting: sign application, saturation and zeroing outside DONE.
  always_comb begin
    out_valid_o = (state_q == DONE);
    q_o         = '0;
    dbz_o       = 1'b0;
    ovf_o       = 1'b0;
    if (state_q == DONE) begin
      if (dbz_q) begin
        dbz_o = 1'b1;
        q_o   = sign_q ? QMIN : QMAX;
      end else if (sign_q) begin
        if (neg_ovf) begin
          q_o   = QMIN;
          ovf_o = 1'b1;
        end else begin
          q_o = ~quo_q[WL-1:0] + 1'b1;
        end
      end else begin
        if (pos_ovf) begin
          q_o   = QMAX;
          ovf_o = 1'b1;
        end else begin
          q_o = quo_q[WL-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_sfp_div_seq.sv
// Testbench for sfp_div_seq: directed corner cases plus randomized operations,
// compared against an integer-arithmetic reference model.
module tb_sfp_div_seq;

  localparam int IW = 8;
  localparam int QW = 8;
  localparam int WL = IW + QW;
  localparam int N  = WL + QW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] a;
  logic [WL-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] q;
  logic          dbz;
  logic          ovf;

  int n_vec;
  int n_err;

  sfp_div_seq #(.IW(IW), .QW(QW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .q_o         (q),
    .dbz_o       (dbz),
    .ovf_o       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact rational division truncated toward zero, then clamped to the format range.
  task automatic model(input logic [WL-1:0] av, input logic [WL-1:0] bv,
                       output logic [WL-1:0] eq, output logic ed, output logic eo);
    longint sa, sb, num, r, qmax, qmin;
    sa   = longint'($signed(av));
    sb   = longint'($signed(bv));
    qmax = (longint'(1) << (WL - 1)) - 1;
    qmin = -(longint'(1) << (WL - 1));
    ed   = 1'b0;
    eo   = 1'b0;
    if (sb == 0) begin
      ed = 1'b1;
      r  = (sa < 0) ? qmin : qmax;
    end else begin
      num = sa * (longint'(1) << QW);
      r   = num / sb;
      if (r > qmax) begin
        r  = qmax;
        eo = 1'b1;
      end else if (r < qmin) begin
        r  = qmin;
        eo = 1'b1;
      end
    end
    eq = WL'(r);
  endtask

  task automatic run_op(input logic [WL-1:0] av, input logic [WL-1:0] bv, input int hold);
    logic [WL-1:0] eq;
    logic          ed, eo;
    int            lat;
    int            exp_lat;
    model(av, bv, eq, ed, eo);
    exp_lat = (bv == '0) ? 1 : N;
    @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    for (int k = 0; k < N + 8; k++) begin
      @(negedge clk);
      if (out_valid) break;
      // Inputs are garbage while busy and must be ignored.
      a        = WL'($urandom);
      b        = WL'($urandom);
      in_valid = 1'($urandom);
      check_eq("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("q", 32'(q), 32'(eq));
    check_eq("dbz", 32'(dbz), 32'(ed));
    check_eq("ovf", 32'(ovf), 32'(eo));
    for (int h = 0; h < hold; h++) begin
      a        = WL'($urandom);
      b        = WL'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_q", 32'(q), 32'(eq));
      check_eq("hold_flags", {30'd0, dbz, ovf}, {30'd0, ed, eo});
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    // Consume edge must not also accept the pending in_valid.
    check_eq("consumed_valid", 32'(out_valid), 32'd0);
    check_eq("consumed_in_ready", 32'(in_ready), 32'd1);
    check_eq("consumed_zero", {15'd0, q, dbz, ovf}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int stray;
    logic [WL-1:0] ra, rb;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_outputs", {14'd0, out_valid, q, dbz, ovf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h0300, 16'h0200, 2);
    run_op(16'hFF00, 16'h0300, 1);
    run_op(16'h8000, 16'h0100, 0);
    run_op(16'h7F00, 16'h0080, 1);
    run_op(16'h8000, 16'hFF00, 0);
    run_op(16'hFE00, 16'h0000, 1);
    run_op(16'h0000, 16'h0000, 0);
    run_op(16'h0100, 16'h8000, 0);
    run_op(16'h8000, 16'h8000, 0);
    run_op(16'h0555, 16'hFD00, 10);

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    a        = 16'h1234;
    b        = 16'h0321;
    in_valid = 1'b1;
    @(posedge clk);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midreset_in_ready", 32'(in_ready), 32'd1);
    check_eq("midreset_outputs", {14'd0, out_valid, q, dbz, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (N + 6) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check_eq("no_result_after_reset", 32'(stray), 32'd0);
    run_op(16'h1234, 16'h0321, 1);

    for (int i = 0; i < 60; i++) begin
      ra = WL'($urandom);
      rb = WL'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 9) == 0) ra = 16'h8000;
      if ($urandom_range(0, 5) == 0) rb = WL'($signed(4'($urandom)));
      run_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfp_div_seq.md
SFP_DIV_SEQ -- requirements
Module: sfp_div_seq

Interface
REQ-001 SHALL have parameter IW, default 8: integer bits of operands and result, sign included; legal range 2 or more.
REQ-002 SHALL have parameter QW, default 8: fractional bits of operands and result; legal range 1 or more.
REQ-003 SHALL derive WL = IW+QW and N = WL+QW as localparams.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid_i, input, 1 bit: dividend and divisor are valid.
REQ-007 SHALL have port in_ready_o, output, 1 bit: block accepts a new operation.
REQ-008 SHALL have port a_i, input, WL bits: signed fixed-point dividend (IW.QW).
REQ-009 SHALL have port b_i, input, WL bits: signed fixed-point divisor (IW.QW).
REQ-010 SHALL have port out_valid_o, output, 1 bit: result and flags are valid.
REQ-011 SHALL have port out_ready_i, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port q_o, output, WL bits: signed fixed-point quotient (IW.QW).
REQ-013 SHALL have port dbz_o, output, 1 bit: divide-by-zero occurred.
REQ-014 SHALL have port ovf_o, output, 1 bit: quotient saturated.

Function
REQ-015 SHALL implement states IDLE, CALC and DONE.
REQ-016 SHALL drive in_ready_o = 1 only in IDLE, with no input buffering.
REQ-017 SHALL accept an operation on a rising edge with in_valid_i && in_ready_o, latching a_i and b_i and result sign = sign(a) XOR sign(b).
REQ-018 SHALL, on accept with b_i != 0, go to CALC with magnitude dividend |a|<<QW (N bits) and magnitude divisor |b|, where |0x80..0| = 2^(WL-1) exactly.
REQ-019 SHALL, in CALC, produce one quotient bit per cycle by unsigned restoring division (MSB first), taking exactly N cycles; on the Nth iteration edge it goes to DONE.
REQ-020 SHALL, with the accept edge counted as edge 0, assert out_valid_o after edge N.
REQ-021 SHALL truncate the quotient toward zero; the remainder is discarded.
REQ-022 SHALL, for sign positive and magnitude > 2^(WL-1)-1, output q_o = max positive (0x7F..F) with ovf_o = 1.
REQ-023 SHALL, for sign negative and magnitude > 2^(WL-1), output q_o = min negative (0x80..0) with ovf_o = 1.
REQ-024 SHALL, when there is no overflow, output q_o = sign-applied magnitude with ovf_o = 0.
REQ-025 SHALL, on accept with b_i == 0, go to DONE after edge 1 with dbz_o = 1 and ovf_o = 0; q_o = 0x7F..F if a_i >= 0, else 0x80..0.
REQ-026 SHALL hold q_o, dbz_o, ovf_o and out_valid_o stable in DONE until out_ready_i = 1; then it goes to IDLE on that edge.
REQ-027 SHALL NOT accept a new operation on the same edge that the result is consumed; in_ready_o rises in the following cycle.
REQ-028 SHALL ignore in_valid_i, a_i and b_i in CALC and DONE; changes there SHALL NOT affect the result.
REQ-029 SHALL ignore out_ready_i outside DONE.
REQ-030 SHALL drive q_o, dbz_o and ovf_o to 0 whenever out_valid_o = 0.

Reset
REQ-031 SHALL, when rst_ni = 0, immediately and asynchronously enter IDLE with in_ready_o = 1, out_valid_o = 0, q_o = 0, dbz_o = 0, ovf_o = 0, iteration counter 0.
REQ-032 SHALL, on reset asserted in CALC or DONE, discard the operation and produce no result after reset release.
REQ-033 SHALL, after reset release, accept a new operation on the first rising edge with in_valid_i = 1.

Verification (IW=8, QW=8, N=24)
REQ-034 SHALL cover basic division: a=0x0300 (3.0), b=0x0200 (2.0) -> out_valid_o after edge 24, q_o=0x0180, dbz_o=0, ovf_o=0.
REQ-035 SHALL cover signs and truncation: a=0xFF00 (-1.0), b=0x0300 (3.0) -> q_o=0xFFAB (-0x55, truncated toward zero); a=0x8000, b=0x0100 -> q_o=0x8000, ovf_o=0.
REQ-036 SHALL cover saturation: a=0x7F00, b=0x0080 -> q_o=0x7FFF, ovf_o=1; a=0x8000, b=0xFF00 -> q_o=0x7FFF, ovf_o=1.
REQ-037 SHALL cover divide-by-zero: a=0xFE00, b=0 -> out_valid_o after edge 1, q_o=0x8000, dbz_o=1; a=0, b=0 -> q_o=0x7FFF, dbz_o=1.
REQ-038 SHALL cover backpressure: hold out_ready_i = 0 for 10 cycles in DONE while toggling a_i and b_i -> outputs stable; in_ready_o = 0 until the cycle after out_ready_i = 1.
REQ-039 SHALL cover reset mid-operation: assert rst_ni = 0 at CALC iteration 12 -> outputs zero immediately; no out_valid_o follows; the next operation completes with the correct q_o.
